stream_mux_rr: RTL and testbench

//  Parametrised N-channel, WIDTH-bit stream multiplexer with a registered output stage.

---
 rtl/stream_mux_rr_pkg.sv | 9 +
 rtl/stream_mux_rr_if.sv | 29 ++
 rtl/stream_mux_rr_pick.sv | 32 +++
 rtl/stream_mux_rr.sv | 110 +++++++++++
 tb/tb_stream_mux_rr.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream_mux_rr block: arbitration mode encodings.
package stream_mux_rr_pkg;

    typedef enum int {
        MODE_SEL = 0,
        MODE_RR  = 1
    } mux_mode_e;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Producer/consumer handshake bundle for stream_mux_rr; the mux uses the slave view.
interface stream_mux_rr_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    import stream_mux_rr_pkg::*;

    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_ready;

    modport slave (
        input  in_valid, in_data, sel, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );

    modport master (
        output in_valid, in_data, sel, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

endinterface

// File: rtl/stream_mux_rr_pick.sv
// Rotate-priority encoder: first set request after ptr, wrapping at CHANNELS-1 -> 0.
module rr_pick
    import stream_mux_rr_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    gnt,
    output logic                any
);

    always_comb begin
        logic [SEL_W:0] idx;
        gnt = '0;
        any = 1'b0;
        idx = '0;
        // Walk from the farthest candidate back so the nearest one after ptr wins.
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = {1'b0, ptr} + (SEL_W+1)'(k);
            if (idx >= (SEL_W+1)'(CHANNELS)) begin
                idx = idx - (SEL_W+1)'(CHANNELS);
            end
            if (req[idx[SEL_W-1:0]]) begin
                gnt = idx[SEL_W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with one registered output stage and
// either external-select or round-robin arbitration.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0
) (
    input  logic           clk,
    input  logic           reset_n,
    stream_mux_rr_if.slave bus
);

    localparam int SEL_W = $clog2(CHANNELS);

    logic [WIDTH-1:0]    ch_data [CHANNELS];
    logic [SEL_W-1:0]    gnt;
    logic                gnt_vld;
    logic                can_load;
    logic                xfer_in;
    logic                xfer_out;
    logic [CHANNELS-1:0] in_ready_o;

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SEL_W-1:0]    out_chan_q,  out_chan_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    if (MODE == int'(MODE_RR)) begin : g_rr
        logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
        logic             pick_any;
        logic             unused_sel;

        rr_pick #(.CHANNELS(CHANNELS)) u_pick (
            .req (bus.in_valid),
            .ptr (rr_ptr_q),
            .gnt (gnt),
            .any (pick_any)
        );

        assign gnt_vld    = pick_any;
        assign unused_sel = ^bus.sel;

        // Pointer only advances on an accepted word, so idle cycles never skip a channel.
        always_comb begin
            rr_ptr_d = rr_ptr_q;
            if (xfer_in) begin
                rr_ptr_d = gnt;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rr_ptr_q <= SEL_W'(CHANNELS - 1);
            end else begin
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end else begin : g_sel
        assign gnt     = bus.sel;
        assign gnt_vld = ({1'b0, bus.sel} < (SEL_W+1)'(CHANNELS));
    end

    // Reset also closes the input side so no producer sees a handshake that gets dropped.
    assign can_load = reset_n & (~out_valid_q | bus.out_ready);
    assign xfer_in  = gnt_vld & can_load & bus.in_valid[gnt];
    assign xfer_out = out_valid_q & bus.out_ready;

    always_comb begin
        in_ready_o = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready_o[i] = gnt_vld & can_load & (gnt == SEL_W'(i));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (xfer_in) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[gnt];
            out_chan_d  = gnt;
        end else if (xfer_out) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign bus.in_ready  = in_ready_o;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: select and round-robin modes, 4- and 3-channel builds.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    stream_mux_rr_if #(.WIDTH(32), .CHANNELS(4)) ia ();
    stream_mux_rr_if #(.WIDTH(32), .CHANNELS(4)) ib ();
    stream_mux_rr_if #(.WIDTH(32), .CHANNELS(3)) ic ();
    stream_mux_rr_if #(.WIDTH(32), .CHANNELS(3)) id ();

    stream_mux_rr #(.WIDTH(32), .CHANNELS(4), .MODE(0)) u_sel4 (.clk(clk), .reset_n(reset_n), .bus(ia));
    stream_mux_rr #(.WIDTH(32), .CHANNELS(4), .MODE(1)) u_rr4  (.clk(clk), .reset_n(reset_n), .bus(ib));
    stream_mux_rr #(.WIDTH(32), .CHANNELS(3), .MODE(0)) u_sel3 (.clk(clk), .reset_n(reset_n), .bus(ic));
    stream_mux_rr #(.WIDTH(32), .CHANNELS(3), .MODE(1)) u_rr3  (.clk(clk), .reset_n(reset_n), .bus(id));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_rr[4];
        int exp_w3[4];
        exp_rr = '{1, 3, 1, 3};
        exp_w3 = '{0, 1, 2, 0};

        reset_n = 1'b0;
        ia.in_valid = '0; ia.in_data = '0; ia.sel = '0; ia.out_ready = 1'b0;
        ib.in_valid = '0; ib.in_data = '0; ib.sel = '0; ib.out_ready = 1'b0;
        ic.in_valid = '0; ic.in_data = '0; ic.sel = '0; ic.out_ready = 1'b0;
        id.in_valid = '0; id.in_data = '0; id.sel = '0; id.out_ready = 1'b0;

        // Reset held two cycles with every channel requesting
        ia.in_valid = 4'hF; ia.out_ready = 1'b1;
        ib.in_valid = 4'hF; ib.out_ready = 1'b1;
        tick();
        tick();
        check("rst_a_valid", ia.out_valid, 0);
        check("rst_a_data",  ia.out_data,  0);
        check("rst_a_chan",  ia.out_chan,  0);
        check("rst_a_ready", ia.in_ready,  0);
        check("rst_b_ready", ib.in_ready,  0);
        check("rst_b_valid", ib.out_valid, 0);
        ia.in_valid = '0;
        ib.in_valid = '0;
        reset_n = 1'b1;
        tick();

        // Select mode, single transfer on ch2
        ia.sel = 2'd2;
        ia.in_valid = 4'b0100;
        ia.in_data[64 +: 32] = 32'hDEAD_BEEF;
        #1;
        check("sel_ready_pre", ia.in_ready, 4'b0100);
        tick();
        check("sel_valid", ia.out_valid, 1);
        check("sel_data",  ia.out_data,  32'hDEAD_BEEF);
        check("sel_chan",  ia.out_chan,  2);
        check("sel_ready_post", ia.in_ready, 4'b0100);
        ia.in_valid = '0;
        tick();
        check("sel_drain_valid", ia.out_valid, 0);
        check("sel_drain_hold",  ia.out_data,  32'hDEAD_BEEF);

        // Backpressure: stall five cycles, then release with a new word ready
        ia.sel = 2'd1;
        ia.in_valid = 4'b0010;
        ia.in_data[32 +: 32] = 32'h1;
        ia.out_ready = 1'b0;
        tick();
        check("bp_load_valid", ia.out_valid, 1);
        ia.in_data[32 +: 32] = 32'h2;
        for (int i = 0; i < 5; i++) begin
            check("bp_stall_ready", ia.in_ready, 0);
            check("bp_stall_data",  ia.out_data, 32'h1);
            tick();
        end
        ia.out_ready = 1'b1;
        #1;
        check("bp_release_ready", ia.in_ready, 4'b0010);
        tick();
        check("bp_next_data",  ia.out_data,  32'h2);
        check("bp_next_valid", ia.out_valid, 1);
        ia.in_valid = '0;
        tick();
        check("bp_empty", ia.out_valid, 0);

        // Out-of-range select on a 3-channel build, then an in-range control
        ic.sel = 2'd3;
        ic.in_valid = 3'b111;
        ic.in_data[64 +: 32] = 32'hC2C2_C2C2;
        ic.out_ready = 1'b1;
        #1;
        check("oor_ready", ic.in_ready, 0);
        tick();
        tick();
        check("oor_valid", ic.out_valid, 0);
        ic.sel = 2'd2;
        #1;
        check("inr_ready", ic.in_ready, 3'b100);
        tick();
        check("inr_chan", ic.out_chan, 2);
        check("inr_data", ic.out_data, 32'hC2C2_C2C2);
        ic.in_valid = '0;

        // Reset while a word is buffered
        ia.sel = 2'd0;
        ia.in_valid = 4'b0001;
        ia.in_data[0 +: 32] = 32'h55;
        ia.out_ready = 1'b0;
        tick();
        check("mid_load_valid", ia.out_valid, 1);
        ia.in_valid = '0;
        reset_n = 1'b0;
        tick();
        check("mid_rst_valid", ia.out_valid, 0);
        check("mid_rst_data",  ia.out_data,  0);
        reset_n = 1'b1;
        tick();

        // Round-robin, all channels requesting from reset
        for (int i = 0; i < 4; i++) begin
            ib.in_data[i*32 +: 32] = 32'hB0 + i;
        end
        ib.in_valid = 4'hF;
        ib.out_ready = 1'b1;
        #1;
        check("rr_first_ready", ib.in_ready, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_all_chan", ib.out_chan, i % 4);
            check("rr_all_data", ib.out_data, 32'hB0 + (i % 4));
        end
        ib.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_odd_chan", ib.out_chan, exp_rr[i]);
        end

        // Pointer holds across idle cycles
        ib.in_valid = '0;
        tick();
        check("rr_idle_valid", ib.out_valid, 0);
        tick();
        tick();
        check("rr_idle_hold_valid", ib.out_valid, 0);
        check("rr_idle_hold_chan",  ib.out_chan,  3);
        ib.in_valid = 4'hF;
        #1;
        check("rr_resume_ready", ib.in_ready, 4'b0001);
        tick();
        check("rr_resume_chan", ib.out_chan, 0);
        ib.in_valid = '0;

        // Round-robin wrap on a non-power-of-two channel count
        id.in_valid = 3'b111;
        id.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr3_chan", id.out_chan, exp_w3[i]);
        end
        id.in_valid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
